rpc2_ctrl_axi_reg_if: RTL and testbench

RPC2_CTRL_AXI_REG_IF -- requirements
Module: rpc2_ctrl_axi_reg_if

---
 rtl/rpc2_ctrl_axi_reg_if.sv | 211 +++++++++++++++++++++
 tb/tb_rpc2_ctrl_axi_reg_if.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpc2_ctrl_axi_reg_if.sv
// AXI4-Lite slave front-end for the RPC2 controller register block.
// Translates one AXI4-Lite transaction at a time into single-cycle register
// strobes (reg_wr_en / reg_rd_en) and returns the response. Register index is
// addr[6:2]; indices above MAX_REG_IDX answer SLVERR with no strobe.
module rpc2_ctrl_axi_reg_if #(
  parameter int unsigned MAX_REG_IDX = 19
) (
  input  logic        clk,
  input  logic        reset_n,
  // Write address channel
  input  logic [6:0]  s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  // Write data channel
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  // Write response channel
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  // Read address channel
  input  logic [6:0]  s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  // Read data channel
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  // Register block side
  output logic [4:0]  reg_addr,
  output logic [31:0] reg_din,
  output logic [3:0]  reg_wr_en,
  output logic        reg_rd_en,
  input  logic [31:0] reg_dout
);

  localparam logic [4:0] MaxIdx = 5'(MAX_REG_IDX);
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StWrWait,
    StWrExec,
    StWrResp,
    StRdExec,
    StRdResp
  } state_e;

  state_e      state_q, state_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [4:0]  aw_idx_q, aw_idx_d;
  logic [31:0] w_data_q, w_data_d;
  logic [3:0]  w_strb_q, w_strb_d;
  logic        err_q, err_d;
  // 1 when the most recently granted transaction was a write
  logic        last_wr_q, last_wr_d;
  logic [4:0]  reg_addr_q, reg_addr_d;
  logic [31:0] reg_din_q, reg_din_d;
  logic [3:0]  reg_wr_en_q, reg_wr_en_d;
  logic        reg_rd_en_q, reg_rd_en_d;

  logic        read_grant;
  logic        aw_hs, w_hs, ar_hs;
  logic [4:0]  ar_idx, aw_idx_eff;
  logic [31:0] w_data_eff;
  logic [3:0]  w_strb_eff;
  logic        ar_in_range, aw_in_range;

  // Byte-offset bits carry no information for 32-bit registers
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  // Arbitration and channel readies; held low while reset is asserted
  always_comb begin
    read_grant    = s_axi_arvalid & (~(s_axi_awvalid | s_axi_wvalid) | last_wr_q);
    s_axi_arready = reset_n & (state_q == StIdle) & read_grant;
    s_axi_awready = reset_n & (((state_q == StIdle) & ~read_grant) |
                               ((state_q == StWrWait) & ~aw_done_q));
    s_axi_wready  = reset_n & (((state_q == StIdle) & ~read_grant) |
                               ((state_q == StWrWait) & ~w_done_q));
    aw_hs = s_axi_awvalid & s_axi_awready;
    w_hs  = s_axi_wvalid & s_axi_wready;
    ar_hs = s_axi_arvalid & s_axi_arready;
  end

  // Operand selection: use captured AW/W if already taken, else the live bus
  always_comb begin
    ar_idx      = s_axi_araddr[6:2];
    aw_idx_eff  = aw_done_q ? aw_idx_q : s_axi_awaddr[6:2];
    w_data_eff  = w_done_q ? w_data_q : s_axi_wdata;
    w_strb_eff  = w_done_q ? w_strb_q : s_axi_wstrb;
    ar_in_range = (ar_idx <= MaxIdx);
    aw_in_range = (aw_idx_eff <= MaxIdx);
  end

  // Next-state and registered register-port values
  always_comb begin
    state_d     = state_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    aw_idx_d    = aw_idx_q;
    w_data_d    = w_data_q;
    w_strb_d    = w_strb_q;
    err_d       = err_q;
    last_wr_d   = last_wr_q;
    reg_addr_d  = reg_addr_q;
    reg_din_d   = reg_din_q;
    reg_wr_en_d = 4'h0;
    reg_rd_en_d = 1'b0;

    if (aw_hs) begin
      aw_idx_d = s_axi_awaddr[6:2];
    end
    if (w_hs) begin
      w_data_d = s_axi_wdata;
      w_strb_d = s_axi_wstrb;
    end

    unique case (state_q)
      StIdle, StWrWait: begin
        if (ar_hs) begin
          state_d     = StRdExec;
          last_wr_d   = 1'b0;
          reg_addr_d  = ar_idx;
          reg_rd_en_d = ar_in_range;
          err_d       = ~ar_in_range;
        end else if (aw_hs || w_hs) begin
          last_wr_d = 1'b1;
          if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
            state_d     = StWrExec;
            aw_done_d   = 1'b0;
            w_done_d    = 1'b0;
            reg_addr_d  = aw_idx_eff;
            reg_din_d   = w_data_eff;
            reg_wr_en_d = aw_in_range ? w_strb_eff : 4'h0;
            err_d       = ~aw_in_range;
          end else begin
            state_d   = StWrWait;
            aw_done_d = aw_done_q | aw_hs;
            w_done_d  = w_done_q | w_hs;
          end
        end
      end
      StWrExec: state_d = StWrResp;
      StWrResp: begin
        if (s_axi_bready) begin
          state_d = StIdle;
        end
      end
      StRdExec: state_d = StRdResp;
      StRdResp: begin
        if (s_axi_rready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and register-port registers; reset abandons any transaction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      aw_idx_q    <= '0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      err_q       <= 1'b0;
      last_wr_q   <= 1'b1;
      reg_addr_q  <= '0;
      reg_din_q   <= '0;
      reg_wr_en_q <= '0;
      reg_rd_en_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      aw_idx_q    <= aw_idx_d;
      w_data_q    <= w_data_d;
      w_strb_q    <= w_strb_d;
      err_q       <= err_d;
      last_wr_q   <= last_wr_d;
      reg_addr_q  <= reg_addr_d;
      reg_din_q   <= reg_din_d;
      reg_wr_en_q <= reg_wr_en_d;
      reg_rd_en_q <= reg_rd_en_d;
    end
  end

  // Response channels decode straight from the state register. rdata passes
  // reg_dout through, which the register block holds until the next read.
  always_comb begin
    s_axi_bvalid = (state_q == StWrResp);
    s_axi_bresp  = (s_axi_bvalid && err_q) ? RespSlvErr : RespOkay;
    s_axi_rvalid = (state_q == StRdResp);
    s_axi_rresp  = (s_axi_rvalid && err_q) ? RespSlvErr : RespOkay;
    s_axi_rdata  = (s_axi_rvalid && !err_q) ? reg_dout : 32'h0;
  end

  assign reg_addr  = reg_addr_q;
  assign reg_din   = reg_din_q;
  assign reg_wr_en = reg_wr_en_q;
  assign reg_rd_en = reg_rd_en_q;

endmodule

// File: tb/tb_rpc2_ctrl_axi_reg_if.sv
// Directed bench for rpc2_ctrl_axi_reg_if. Inputs change 1 time unit after
// the rising edge; outputs are sampled mid-cycle.
module tb_rpc2_ctrl_axi_reg_if;

  logic        clk;
  logic        reset_n;
  logic [6:0]  s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [6:0]  s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [4:0]  reg_addr;
  logic [31:0] reg_din;
  logic [3:0]  reg_wr_en;
  logic        reg_rd_en;
  logic [31:0] reg_dout;

  int n_asserts = 0;
  int n_fail    = 0;

  rpc2_ctrl_axi_reg_if #(
    .MAX_REG_IDX(19)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_axi_awaddr (s_axi_awaddr),
    .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata  (s_axi_wdata),
    .s_axi_wstrb  (s_axi_wstrb),
    .s_axi_wvalid (s_axi_wvalid),
    .s_axi_wready (s_axi_wready),
    .s_axi_bresp  (s_axi_bresp),
    .s_axi_bvalid (s_axi_bvalid),
    .s_axi_bready (s_axi_bready),
    .s_axi_araddr (s_axi_araddr),
    .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rdata  (s_axi_rdata),
    .s_axi_rresp  (s_axi_rresp),
    .s_axi_rvalid (s_axi_rvalid),
    .s_axi_rready (s_axi_rready),
    .reg_addr     (reg_addr),
    .reg_din      (reg_din),
    .reg_wr_en    (reg_wr_en),
    .reg_rd_en    (reg_rd_en),
    .reg_dout     (reg_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register block stand-in: index 1 reads 0x8000_0001, others 0xA000_00nn
  function automatic logic [31:0] rom_word(input logic [4:0] idx);
    return (idx == 5'd1) ? 32'h8000_0001 : (32'hA000_0000 | 32'(idx));
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) reg_dout <= '0;
    else if (reg_rd_en) reg_dout <= rom_word(reg_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic clear_inputs();
    s_axi_awaddr = '0; s_axi_awvalid = 0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 0;
    s_axi_bready = 0;
    s_axi_araddr = '0; s_axi_arvalid = 0;
    s_axi_rready = 0;
  endtask

  initial begin
    reset_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_awready", s_axi_awready, 0);
    check("rst_wready", s_axi_wready, 0);
    check("rst_arready", s_axi_arready, 0);
    check("rst_bvalid", s_axi_bvalid, 0);
    check("rst_rvalid", s_axi_rvalid, 0);
    check("rst_rdata", s_axi_rdata, 0);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_reg_din", reg_din, 0);
    check("rst_reg_wr_en", reg_wr_en, 0);
    check("rst_reg_rd_en", reg_rd_en, 0);
    reset_n = 1'b1;

    // Collision held for 12 cycles: read first, then strict alternation,
    // one transaction every 3 cycles
    s_axi_araddr = 7'h08; s_axi_arvalid = 1;
    s_axi_awaddr = 7'h0C; s_axi_awvalid = 1;
    s_axi_wdata = 32'h1111_2222; s_axi_wstrb = 4'hF; s_axi_wvalid = 1;
    s_axi_rready = 1; s_axi_bready = 1;
    for (int c = 0; c < 12; c++) begin
      settle();
      check($sformatf("coll_arready_c%0d", c), s_axi_arready, 32'(c % 6 == 0));
      check($sformatf("coll_awready_c%0d", c), s_axi_awready, 32'(c % 6 == 3));
      check($sformatf("coll_rd_en_c%0d", c), reg_rd_en, 32'(c % 6 == 1));
      check($sformatf("coll_wr_en_c%0d", c), reg_wr_en, (c % 6 == 4) ? 32'hF : 32'h0);
      check($sformatf("coll_rvalid_c%0d", c), s_axi_rvalid, 32'(c % 6 == 2));
      check($sformatf("coll_bvalid_c%0d", c), s_axi_bvalid, 32'(c % 6 == 5));
      if (c % 6 == 2) check($sformatf("coll_rdata_c%0d", c), s_axi_rdata, 32'hA000_0002);
      next_cycle();
    end
    clear_inputs();

    // Write MCR0 with AW and W together
    s_axi_awaddr = 7'h20; s_axi_awvalid = 1;
    s_axi_wdata = 32'h8000_0031; s_axi_wstrb = 4'hF; s_axi_wvalid = 1;
    settle();
    check("mcr0_awready", s_axi_awready, 1);
    check("mcr0_wready", s_axi_wready, 1);
    next_cycle();
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    settle();
    check("mcr0_wr_en", reg_wr_en, 4'hF);
    check("mcr0_reg_addr", reg_addr, 8);
    check("mcr0_reg_din", reg_din, 32'h8000_0031);
    check("mcr0_bvalid_exec", s_axi_bvalid, 0);
    next_cycle();
    settle();
    check("mcr0_bvalid", s_axi_bvalid, 1);
    check("mcr0_bresp", s_axi_bresp, 0);
    check("mcr0_wr_en_pulse", reg_wr_en, 0);
    next_cycle();
    settle();
    check("mcr0_bvalid_hold", s_axi_bvalid, 1);
    s_axi_bready = 1;
    next_cycle();
    s_axi_bready = 0;
    settle();
    check("mcr0_bvalid_done", s_axi_bvalid, 0);
    check("mcr0_din_held", reg_din, 32'h8000_0031);

    // W three cycles ahead of AW
    s_axi_wdata = 32'h0000_AB00; s_axi_wstrb = 4'h2; s_axi_wvalid = 1;
    settle();
    check("early_w_wready", s_axi_wready, 1);
    next_cycle();
    s_axi_wvalid = 0;
    for (int k = 0; k < 2; k++) begin
      settle();
      check($sformatf("early_w_wait_wr_en_%0d", k), reg_wr_en, 0);
      check($sformatf("early_w_wait_wready_%0d", k), s_axi_wready, 0);
      next_cycle();
    end
    s_axi_awaddr = 7'h30; s_axi_awvalid = 1;
    settle();
    check("early_w_awready", s_axi_awready, 1);
    check("early_w_wr_en_pre", reg_wr_en, 0);
    next_cycle();
    s_axi_awvalid = 0;
    settle();
    check("early_w_wr_en", reg_wr_en, 4'h2);
    check("early_w_reg_addr", reg_addr, 12);
    check("early_w_reg_din", reg_din, 32'h0000_AB00);
    s_axi_bready = 1;
    next_cycle();
    settle();
    check("early_w_bvalid", s_axi_bvalid, 1);
    check("early_w_wr_en_after", reg_wr_en, 0);
    next_cycle();
    s_axi_bready = 0;
    settle();
    check("early_w_bvalid_done", s_axi_bvalid, 0);

    // Read 0x04 with rready held low for 5 cycles
    s_axi_araddr = 7'h04; s_axi_arvalid = 1;
    settle();
    check("rd04_arready", s_axi_arready, 1);
    next_cycle();
    s_axi_arvalid = 0;
    settle();
    check("rd04_rd_en", reg_rd_en, 1);
    check("rd04_reg_addr", reg_addr, 1);
    check("rd04_rvalid_exec", s_axi_rvalid, 0);
    next_cycle();
    for (int k = 0; k < 5; k++) begin
      settle();
      check($sformatf("rd04_rvalid_%0d", k), s_axi_rvalid, 1);
      check($sformatf("rd04_rdata_%0d", k), s_axi_rdata, 32'h8000_0001);
      check($sformatf("rd04_rresp_%0d", k), s_axi_rresp, 0);
      check($sformatf("rd04_rd_en_%0d", k), reg_rd_en, 0);
      next_cycle();
    end
    s_axi_rready = 1;
    settle();
    check("rd04_rdata_hs", s_axi_rdata, 32'h8000_0001);
    next_cycle();
    s_axi_rready = 0;
    settle();
    check("rd04_rvalid_done", s_axi_rvalid, 0);

    // Highest in-range index (19), address LSBs set
    s_axi_araddr = 7'h4E; s_axi_arvalid = 1; s_axi_rready = 1;
    next_cycle();
    s_axi_arvalid = 0;
    settle();
    check("rd19_rd_en", reg_rd_en, 1);
    check("rd19_reg_addr", reg_addr, 19);
    next_cycle();
    settle();
    check("rd19_rvalid", s_axi_rvalid, 1);
    check("rd19_rdata", s_axi_rdata, 32'hA000_0013);
    check("rd19_rresp", s_axi_rresp, 0);
    next_cycle();
    s_axi_rready = 0;

    // Out-of-range read (index 20) and write (index 31)
    s_axi_araddr = 7'h50; s_axi_arvalid = 1; s_axi_rready = 1;
    next_cycle();
    s_axi_arvalid = 0;
    settle();
    check("oor_rd_en", reg_rd_en, 0);
    next_cycle();
    settle();
    check("oor_rvalid", s_axi_rvalid, 1);
    check("oor_rresp", s_axi_rresp, 2'b10);
    check("oor_rdata", s_axi_rdata, 0);
    next_cycle();
    s_axi_rready = 0;
    s_axi_awaddr = 7'h7C; s_axi_awvalid = 1;
    s_axi_wdata = 32'hFFFF_FFFF; s_axi_wstrb = 4'hF; s_axi_wvalid = 1;
    s_axi_bready = 1;
    next_cycle();
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    settle();
    check("oor_wr_en", reg_wr_en, 0);
    next_cycle();
    settle();
    check("oor_bvalid", s_axi_bvalid, 1);
    check("oor_bresp", s_axi_bresp, 2'b10);
    next_cycle();
    s_axi_bready = 0;

    // In-range write with all strobes clear
    s_axi_awaddr = 7'h14; s_axi_awvalid = 1;
    s_axi_wdata = 32'h5555_AAAA; s_axi_wstrb = 4'h0; s_axi_wvalid = 1;
    s_axi_bready = 1;
    next_cycle();
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    settle();
    check("zstrb_wr_en", reg_wr_en, 0);
    check("zstrb_reg_addr", reg_addr, 5);
    next_cycle();
    settle();
    check("zstrb_bvalid", s_axi_bvalid, 1);
    check("zstrb_bresp", s_axi_bresp, 0);
    next_cycle();
    s_axi_bready = 0;

    // Reset during WR_WAIT
    s_axi_wdata = 32'hDEAD_BEEF; s_axi_wstrb = 4'hF; s_axi_wvalid = 1;
    next_cycle();
    s_axi_wvalid = 0;
    settle();
    check("rstww_awready_wait", s_axi_awready, 1);
    reset_n = 0;
    s_axi_awvalid = 1; s_axi_wvalid = 1; s_axi_arvalid = 1;
    #1;
    check("rstww_awready", s_axi_awready, 0);
    check("rstww_wready", s_axi_wready, 0);
    check("rstww_arready", s_axi_arready, 0);
    check("rstww_bvalid", s_axi_bvalid, 0);
    check("rstww_reg_addr", reg_addr, 0);
    check("rstww_reg_din", reg_din, 0);
    clear_inputs();
    next_cycle();
    reset_n = 1;

    // Reset during RD_RESP
    s_axi_araddr = 7'h08; s_axi_arvalid = 1;
    next_cycle();
    s_axi_arvalid = 0;
    next_cycle();
    settle();
    check("rstrr_rvalid_pre", s_axi_rvalid, 1);
    reset_n = 0;
    s_axi_arvalid = 1;
    #1;
    check("rstrr_rvalid", s_axi_rvalid, 0);
    check("rstrr_rdata", s_axi_rdata, 0);
    check("rstrr_rresp", s_axi_rresp, 0);
    check("rstrr_arready", s_axi_arready, 0);
    check("rstrr_rd_en", reg_rd_en, 0);
    clear_inputs();
    next_cycle();
    reset_n = 1;

    // Write to 0x44 after reset, AW then W: no leftover W may complete it early
    s_axi_awaddr = 7'h44; s_axi_awvalid = 1;
    settle();
    check("w44_awready", s_axi_awready, 1);
    next_cycle();
    s_axi_awvalid = 0;
    settle();
    check("w44_wr_en_wait", reg_wr_en, 0);
    check("w44_bvalid_wait", s_axi_bvalid, 0);
    next_cycle();
    s_axi_wdata = 32'h0044_0044; s_axi_wstrb = 4'hF; s_axi_wvalid = 1;
    settle();
    check("w44_wready", s_axi_wready, 1);
    next_cycle();
    s_axi_wvalid = 0;
    settle();
    check("w44_wr_en", reg_wr_en, 4'hF);
    check("w44_reg_addr", reg_addr, 17);
    check("w44_reg_din", reg_din, 32'h0044_0044);
    s_axi_bready = 1;
    next_cycle();
    settle();
    check("w44_bvalid", s_axi_bvalid, 1);
    check("w44_bresp", s_axi_bresp, 0);
    next_cycle();
    s_axi_bready = 0;
    settle();
    check("w44_bvalid_done", s_axi_bvalid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
